// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - state codes, instruction fields and selector constants for cpu_control_unit
package cpu_ctrl_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_FETCH     = 3'd1;
   localparam state_t ST_DECODE    = 3'd2;
   localparam state_t ST_MEMWAIT   = 3'd3;
   localparam state_t ST_EXEC      = 3'd4;
   localparam state_t ST_HALT      = 3'd5;
   localparam state_t ST_STEP_WAIT = 3'd6;

   typedef enum logic [1:0] {
      OP_JMP  = 2'b00,
      OP_JZ   = 2'b01,
      OP_JC   = 2'b10,
      OP_HALT = 2'b11
   } ctrl_op_e;

   localparam logic [2:0] CTRL_CLASS = 3'b111;
   localparam logic [1:0] SEL_MEM    = 2'b01;

   localparam int CLASS_HI = 15;
   localparam int CLASS_LO = 13;
   localparam int SUBOP_HI = 12;
   localparam int SUBOP_LO = 11;

endpackage

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - multi-cycle sequencer owning pc/ir and gating datapath write enables
// Optional single-step support is enabled with `define CPU_CTRL_SINGLE_STEP_EN.
module cpu_control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int PC_WIDTH    = 5,
   parameter int MEM_LATENCY = 1
) (
   input  logic                clk,
   input  logic                rst,
`ifdef CPU_CTRL_SINGLE_STEP_EN
   input  logic                step_mode,
   input  logic                step,
`endif
   input  logic                start,
   input  logic [15:0]         instruction,
   input  logic                dec_A_we,
   input  logic                dec_RF_we,
   input  logic                dec_MEM_we,
   input  logic [1:0]          dec_selector,
   input  logic                acc_zero,
   input  logic                carry_flag,
   output logic [PC_WIDTH-1:0] pc,
   output logic [15:0]         ir,
   output logic                A_we,
   output logic                RF_we,
   output logic                MEM_we,
   output logic                busy,
   output logic                halted
);

   // Counter only ever holds MEM_LATENCY-1 down to 0.
   localparam int WAIT_W    = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
   localparam int WAIT_INIT = (MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [15:0]         ir_q, ir_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;

   state_t              fetch_st;
   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] target;
   logic                is_ctrl;
   ctrl_op_e            subop;
   logic                in_exec;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      wait_d   = wait_q;
      fetch_st = ST_FETCH;
`ifdef CPU_CTRL_SINGLE_STEP_EN
      if (step_mode) begin
         fetch_st = ST_STEP_WAIT;
      end
`endif
      pc_inc  = pc_q + PC_WIDTH'(1);
      target  = ir_q[PC_WIDTH-1:0];
      is_ctrl = (ir_q[CLASS_HI:CLASS_LO] == CTRL_CLASS);
      subop   = ctrl_op_e'(ir_q[SUBOP_HI:SUBOP_LO]);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = fetch_st;
            end
         end
         ST_FETCH: begin
            ir_d    = instruction;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (is_ctrl) begin
               case (subop)
                  OP_JMP: begin
                     pc_d    = target;
                     state_d = fetch_st;
                  end
                  OP_JZ: begin
                     pc_d    = acc_zero ? target : pc_inc;
                     state_d = fetch_st;
                  end
                  OP_JC: begin
                     pc_d    = carry_flag ? target : pc_inc;
                     state_d = fetch_st;
                  end
                  default: begin
                     state_d = ST_HALT;
                  end
               endcase
            end else if ((dec_selector == SEL_MEM) && (MEM_LATENCY > 0)) begin
               wait_d  = WAIT_W'(WAIT_INIT);
               state_d = ST_MEMWAIT;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_MEMWAIT: begin
            if (wait_q == '0) begin
               state_d = ST_EXEC;
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
         ST_EXEC: begin
            pc_d    = pc_inc;
            state_d = fetch_st;
         end
         ST_HALT: begin
            if (start) begin
               pc_d    = '0;
               state_d = fetch_st;
            end
         end
         ST_STEP_WAIT: begin
`ifdef CPU_CTRL_SINGLE_STEP_EN
            // Dropping step_mode while parked resumes free-running at once.
            if (step || !step_mode) begin
               state_d = ST_FETCH;
            end
`else
            state_d = ST_FETCH;
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         wait_q  <= wait_d;
      end
   end

   // Enables decode straight from the state flop so an async reset kills a pulse immediately.
   assign in_exec = (state_q == ST_EXEC);
   assign A_we    = in_exec & dec_A_we;
   assign RF_we   = in_exec & dec_RF_we;
   assign MEM_we  = in_exec & dec_MEM_we;

   assign busy    = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                    (state_q == ST_MEMWAIT) || (state_q == ST_EXEC);
   assign halted  = (state_q == ST_HALT);
   assign pc      = pc_q;
   assign ir      = ir_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - directed bench for cpu_control_unit against an instruction-level trace model
module tb_cpu_control_unit;

   localparam int LAT = 2;

   typedef struct packed {
      logic [4:0]  pc;
      logic [15:0] ir;
      logic        busy;
      logic        halted;
      logic        a;
      logic        rf;
      logic        mem;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] instruction;
   logic        dec_A_we, dec_RF_we, dec_MEM_we;
   logic [1:0]  dec_selector;
   logic        acc_zero, carry_flag;
   logic [4:0]  pc;
   logic [15:0] ir;
   logic        A_we, RF_we, MEM_we, busy, halted;
`ifdef CPU_CTRL_SINGLE_STEP_EN
   logic        step_mode, step;
`endif

   logic [15:0] prog [0:31];
   exp_t        tr[$];
   exp_t        act[$];
   int          n_chk;
   int          n_fail;

   cpu_control_unit #(.PC_WIDTH(5), .MEM_LATENCY(LAT)) dut (
      .clk(clk),
      .rst(rst),
`ifdef CPU_CTRL_SINGLE_STEP_EN
      .step_mode(step_mode),
      .step(step),
`endif
      .start(start),
      .instruction(instruction),
      .dec_A_we(dec_A_we),
      .dec_RF_we(dec_RF_we),
      .dec_MEM_we(dec_MEM_we),
      .dec_selector(dec_selector),
      .acc_zero(acc_zero),
      .carry_flag(carry_flag),
      .pc(pc),
      .ir(ir),
      .A_we(A_we),
      .RF_we(RF_we),
      .MEM_we(MEM_we),
      .busy(busy),
      .halted(halted)
   );

   // Toy decoder: enables in ir[10:8], operand select in ir[7:6], also live for control words.
   assign instruction  = prog[pc];
   assign dec_A_we     = ir[10];
   assign dec_RF_we    = ir[9];
   assign dec_MEM_we   = ir[8];
   assign dec_selector = ir[7:6];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, want);
      end
   endtask

   task automatic push(input logic [4:0] p, input logic [15:0] i, input logic b,
                       input logic h, input logic [2:0] we);
      exp_t e;
      e = '{p, i, b, h, we[2], we[1], we[0]};
      tr.push_back(e);
   endtask

   // Instruction-level model: each instruction expands into its cycle sequence.
   task automatic build(input int n, input int restart_at);
      logic [4:0]  pcm;
      logic [15:0] irm;
      logic [15:0] ins;
      bit          done;
      tr.delete();
      pcm = '0;
      irm = '0;
      push(pcm, irm, 1'b0, 1'b0, 3'b000);
      while (tr.size() < n) begin
         ins = prog[pcm];
         push(pcm, irm, 1'b1, 1'b0, 3'b000);
         irm = ins;
         push(pcm, irm, 1'b1, 1'b0, 3'b000);
         if (ins[15:13] == 3'b111) begin
            case (ins[12:11])
               2'b00: pcm = ins[4:0];
               2'b01: pcm = acc_zero ? ins[4:0] : pcm + 5'd1;
               2'b10: pcm = carry_flag ? ins[4:0] : pcm + 5'd1;
               default: begin
                  done = 1'b0;
                  while (!done && tr.size() < n) begin
                     push(pcm, irm, 1'b0, 1'b1, 3'b000);
                     if (tr.size() - 1 == restart_at) begin
                        pcm  = '0;
                        done = 1'b1;
                     end
                  end
               end
            endcase
         end else begin
            if (ins[7:6] == 2'b01) begin
               for (int w = 0; w < LAT; w++) push(pcm, irm, 1'b1, 1'b0, 3'b000);
            end
            push(pcm, irm, 1'b1, 1'b0, ins[10:8]);
            pcm = pcm + 5'd1;
         end
      end
   endtask

   task automatic run(input string nm, input int n, input int restart_at);
      exp_t a;
      build(n, restart_at);
      act.delete();
      rst   = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < n; k++) begin
         if (k > 0) @(negedge clk);
         a = '{pc, ir, busy, halted, A_we, RF_we, MEM_we};
         act.push_back(a);
         chk($sformatf("%s_cycle%0d", nm, k), 32'(a), 32'(tr[k]));
         start = (k == 0) || (k == restart_at);
      end
   endtask

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      rst        = 1'b0;
      start      = 1'b0;
      acc_zero   = 1'b0;
      carry_flag = 1'b0;
`ifdef CPU_CTRL_SINGLE_STEP_EN
      step_mode  = 1'b0;
      step       = 1'b0;
`endif

      // Program A: DP, memory-sourced DP, JMP with noisy enable bits, untaken JZ/JC, DP, HALT.
      for (int i = 0; i < 32; i++) prog[i] = 16'h0000;
      prog[0] = 16'h0400;
      prog[1] = 16'h0240;
      prog[2] = 16'hE705;
      prog[5] = 16'hE809;
      prog[6] = 16'hF00C;
      prog[7] = 16'h0100;
      prog[8] = 16'hF800;
      run("progA", 30, 23);
      chk("pinA_reset_pc", 32'(act[0].pc), 32'd0);
      chk("pinA_A_we_c3", 32'(act[3].a), 32'd1);
      chk("pinA_A_we_c2", 32'(act[2].a), 32'd0);
      chk("pinA_pc_c4", 32'(act[4].pc), 32'd1);
      chk("pinA_memwait_busy", 32'({act[6].busy, act[7].busy, act[6].rf, act[7].rf}), 32'b1100);
      chk("pinA_rf_pulse_c8", 32'(act[8].rf), 32'd1);
      chk("pinA_rf_after_c9", 32'(act[9].rf), 32'd0);
      chk("pinA_jmp_no_we", 32'({act[10].a, act[10].rf, act[10].mem}), 32'd0);
      chk("pinA_jmp_target", 32'(act[11].pc), 32'd5);
      chk("pinA_jz_fall", 32'(act[13].pc), 32'd6);
      chk("pinA_jc_fall", 32'(act[15].pc), 32'd7);
      chk("pinA_halt", 32'({act[21].halted, act[21].busy, act[21].pc}), 32'({1'b1, 1'b0, 5'd8}));
      chk("pinA_restart", 32'({act[24].busy, act[24].pc}), 32'({1'b1, 5'd0}));

      // Program B: taken JZ/JC, then pc wrap from 31 to 0.
      acc_zero   = 1'b1;
      carry_flag = 1'b1;
      for (int i = 0; i < 32; i++) prog[i] = 16'h0000;
      prog[0]  = 16'hE809;
      prog[9]  = 16'hF01E;
      prog[30] = 16'h0400;
      prog[31] = 16'h0100;
      run("progB", 14, -1);
      chk("pinB_jz_taken", 32'(act[3].pc), 32'd9);
      chk("pinB_jc_taken", 32'(act[5].pc), 32'd30);
      chk("pinB_exec31_mem", 32'({act[10].pc, act[10].mem}), 32'({5'd31, 1'b1}));
      chk("pinB_wrap", 32'(act[11].pc), 32'd0);

      // Program C: async reset in the middle of an EXEC that writes memory.
      acc_zero   = 1'b0;
      carry_flag = 1'b0;
      for (int i = 0; i < 32; i++) prog[i] = 16'h0000;
      prog[0] = 16'h0100;
      run("progC", 4, -1);
      start = 1'b1;
      #1 rst = 1'b0;
      #1;
      chk("rstC_mem_we_drop", 32'(MEM_we), 32'd0);
      chk("rstC_pc", 32'(pc), 32'd0);
      chk("rstC_ir", 32'(ir), 32'd0);
      chk("rstC_busy_halted", 32'({busy, halted}), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rstC_start_ignored", 32'({busy, pc}), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("rstC_fetch_after_release", 32'({busy, pc, A_we, RF_we, MEM_we}), 32'({1'b1, 5'd0, 3'b000}));
      start = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
